// File: rtl/mult_div.sv
// Signed 32x32 multiply (radix-2 Booth) and signed 32/32 divide (restoring, on
// magnitudes) sharing one iterative datapath. Results land in HI/LO.
module mult_div (
  input  logic        clk,
  input  logic        reset,
  input  logic        mult_start,
  input  logic        div_start,
  input  logic [31:0] Data_A,
  input  logic [31:0] Data_B,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;

  state_t      state;
  logic [5:0]  cnt;
  // acc: Booth partial product (33b so M = -2^31 cannot overflow) or remainder
  // q:   Booth multiplier / shifting quotient
  // m:   multiplicand or divisor magnitude
  logic [32:0] acc;
  logic [31:0] q, m;
  logic        qm1;
  logic        neg_q, neg_r;

  logic [32:0] bsum, acc_nx;
  logic [31:0] q_nx;
  logic        qm1_nx;
  logic [32:0] dshift, dtrial;
  logic [31:0] quo_nx, rem_nx, quo_fin, rem_fin;
  logic [31:0] abs_a, abs_b;

  // Operand magnitudes; 0x80000000 maps to itself, which is correct as unsigned.
  assign abs_a = Data_A[31] ? (~Data_A + 32'd1) : Data_A;
  assign abs_b = Data_B[31] ? (~Data_B + 32'd1) : Data_B;

  // One Booth step: add/sub multiplicand per {q0,q-1}, then arithmetic shift.
  always_comb begin
    bsum = acc;
    case ({q[0], qm1})
      2'b01:   bsum = acc + {m[31], m};
      2'b10:   bsum = acc - {m[31], m};
      default: bsum = acc;
    endcase
    acc_nx = {bsum[32], bsum[32:1]};
    q_nx   = {bsum[0], q[31:1]};
    qm1_nx = q[0];
  end

  // One restoring-divide step plus sign fix-up of the would-be final result.
  always_comb begin
    dshift = {acc[31:0], q[31]};
    dtrial = dshift - {1'b0, m};
    if (dtrial[32]) begin
      rem_nx = dshift[31:0];
      quo_nx = {q[30:0], 1'b0};
    end else begin
      rem_nx = dtrial[31:0];
      quo_nx = {q[30:0], 1'b1};
    end
    quo_fin = neg_q ? (~quo_nx + 32'd1) : quo_nx;
    rem_fin = neg_r ? (~rem_nx + 32'd1) : rem_nx;
  end

  // Control FSM with registered status outputs and HI/LO result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 6'd0;
      hi_out   <= 32'd0;
      lo_out   <= 32'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      acc      <= 33'd0;
      q        <= 32'd0;
      m        <= 32'd0;
      qm1      <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= 6'd0;
          if (mult_start) begin
            acc   <= 33'd0;
            m     <= Data_A;
            q     <= Data_B;
            qm1   <= 1'b0;
            busy  <= 1'b1;
            state <= MULT;
          end else if (div_start) begin
            busy <= 1'b1;
            if (Data_B == 32'd0) begin
              // HI/LO untouched; just flag and finish next cycle
              done     <= 1'b1;
              div_zero <= 1'b1;
              state    <= FINISH;
            end else begin
              acc   <= 33'd0;
              q     <= abs_a;
              m     <= abs_b;
              neg_q <= Data_A[31] ^ Data_B[31];
              neg_r <= Data_A[31];
              state <= DIV;
            end
          end
        end
        MULT: begin
          acc <= acc_nx;
          q   <= q_nx;
          qm1 <= qm1_nx;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            hi_out <= acc_nx[31:0];
            lo_out <= q_nx;
            done   <= 1'b1;
            state  <= FINISH;
          end
        end
        DIV: begin
          acc <= {1'b0, rem_nx};
          q   <= quo_nx;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            hi_out <= rem_fin;
            lo_out <= quo_fin;
            done   <= 1'b1;
            state  <= FINISH;
          end
        end
        FINISH: begin
          cnt   <= 6'd0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div.sv
// Scoreboard bench for mult_div: expected HI/LO/div_zero pushed at start,
// popped and compared whenever done pulses.
module tb_mult_div;
  logic        clk = 1'b0;
  logic        reset, mult_start, div_start;
  logic [31:0] Data_A, Data_B, hi_out, lo_out;
  logic        busy, done, div_zero;

  mult_div dut (
    .clk(clk), .reset(reset), .mult_start(mult_start), .div_start(div_start),
    .Data_A(Data_A), .Data_B(Data_B), .hi_out(hi_out), .lo_out(lo_out),
    .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t        sb[$];
  exp_t        me;
  int          npass = 0, ntot = 0, ndone = 0;
  logic [31:0] mhi = 32'd0, mlo = 32'd0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model, written from the arithmetic definition.
  function automatic exp_t model(input logic is_mult, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic signed [63:0] sa, sb64, p;
    logic signed [31:0] a32, b32;
    if (is_mult) begin
      sa = {{32{a[31]}}, a};
      sb64 = {{32{b[31]}}, b};
      p = sa * sb64;
      e.hi = p[63:32]; e.lo = p[31:0]; e.dz = 1'b0;
    end else if (b == 32'd0) begin
      e.hi = mhi; e.lo = mlo; e.dz = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.hi = 32'd0; e.lo = 32'h8000_0000; e.dz = 1'b0;
    end else begin
      a32 = a; b32 = b;
      e.lo = a32 / b32; e.hi = a32 % b32; e.dz = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard consumer
  always @(negedge clk) begin
    if (done === 1'b1) begin
      ndone++;
      if (sb.size() == 0) chk("spurious_done", 64'd1, 64'd0);
      else begin
        me = sb.pop_front();
        chk("hi", hi_out, me.hi);
        chk("lo", lo_out, me.lo);
        chk("div_zero", div_zero, me.dz);
      end
    end else if (div_zero === 1'b1) chk("dz_without_done", 64'd1, 64'd0);
  end

  task automatic run(input logic ms, input logic ds, input logic [31:0] a, input logic [31:0] b,
                     input int lat, input string tag);
    exp_t e;
    int n;
    @(negedge clk);
    e = model(ms, a, b);
    sb.push_back(e);
    mhi = e.hi; mlo = e.lo;
    mult_start = ms; div_start = ds; Data_A = a; Data_B = b;
    n = 0;
    do begin
      @(negedge clk);
      mult_start = 1'b0; div_start = 1'b0;
      Data_A = $urandom; Data_B = $urandom;
      n++;
      if (n == 1) chk({tag, "_busy1"}, busy, 1);
    end while (done !== 1'b1 && n < 40);
    chk({tag, "_lat"}, n, lat);
    @(negedge clk);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int d0;
    logic [31:0] ra, rb;
    reset = 1'b1; mult_start = 1'b0; div_start = 1'b0; Data_A = '0; Data_B = '0;
    repeat (3) @(negedge clk);
    chk("rst_hi", hi_out, 0); chk("rst_lo", lo_out, 0);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_dz", div_zero, 0);
    reset = 1'b0;

    run(1, 0, 32'd7, 32'd6, 33, "mul_pos");
    run(1, 0, 32'hFFFF_FFFD, 32'd5, 33, "mul_neg");
    run(1, 0, 32'h8000_0000, 32'h8000_0000, 33, "mul_minmin");
    run(1, 0, 32'h8000_0000, 32'h7FFF_FFFF, 33, "mul_minmax");
    run(0, 1, 32'hFFFF_FFF9, 32'd2, 33, "div_neg");
    run(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 33, "div_ovf");
    run(0, 1, 32'd7, 32'hFFFF_FFFE, 33, "div_negb");
    run(0, 1, 32'd3, 32'd10, 33, "div_small");

    // preload HI/LO = 0x11111111 / 0x22222222, then divide by zero
    run(1, 0, 32'h5555_5556, 32'h3333_3333, 33, "preload");
    run(0, 1, 32'd5, 32'd0, 1, "divz");
    chk("divz_hi_kept", hi_out, 32'h1111_1111);
    chk("divz_lo_kept", lo_out, 32'h2222_2222);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom; rb = $urandom;
      if (i % 3 == 2) rb = rb >> (rb[4:0]);
      run(i[0], ~i[0], ra, rb, 33, "rand");
    end

    // abort mid-multiply
    @(negedge clk);
    mult_start = 1'b1; Data_A = 32'd123456; Data_B = 32'd789;
    @(negedge clk);
    mult_start = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mhi = 32'd0; mlo = 32'd0;
    chk("abort_busy", busy, 0); chk("abort_hi", hi_out, 0); chk("abort_lo", lo_out, 0);
    run(0, 1, 32'd100, 32'd7, 33, "div_after_abort");

    // reset wins over a simultaneous start
    @(negedge clk);
    reset = 1'b1; mult_start = 1'b1; Data_A = 32'd9; Data_B = 32'd9;
    @(negedge clk);
    reset = 1'b0; mult_start = 1'b0;
    mhi = 32'd0; mlo = 32'd0;
    chk("rst_start_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("rst_start_still_idle", busy, 0);

    // both starts: multiply wins; a divide start while busy is dropped
    d0 = ndone;
    @(negedge clk);
    me = model(1, 32'd3, 32'd4);
    sb.push_back(me); mhi = me.hi; mlo = me.lo;
    mult_start = 1'b1; div_start = 1'b1; Data_A = 32'd3; Data_B = 32'd4;
    @(negedge clk);
    mult_start = 1'b0; div_start = 1'b0;
    repeat (5) @(negedge clk);
    div_start = 1'b1; Data_A = 32'd50; Data_B = 32'd0;
    @(negedge clk);
    div_start = 1'b0;
    repeat (40) @(negedge clk);
    chk("prio_one_done", ndone - d0, 1);
    chk("prio_lo", lo_out, 32'd12);

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
